// File: rtl/range_count_monitor.sv
// Checks the LO..HI count stream of the upstream range counter, pulses once per completed lap, and flags breaks.
// Latency: every output is registered, one cycle after the count sample it reflects.
// Backpressure: none; a new count is consumed on every clock edge.
module range_count_monitor #(
    parameter int DW       = 8,
    parameter int LO       = 3,
    parameter int HI       = 45,
    parameter int LOCK_LEN = 4,
    parameter int LAP_W    = 16,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    count,
    input  logic             clr,
    output logic             locked,
    output logic             wrap_pulse,
    output logic [LAP_W-1:0] lap_count,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
);

    // The run counter only has to reach LOCK_LEN-1 before lock is declared.
    localparam int RUN_W = (LOCK_LEN > 1) ? $clog2(LOCK_LEN) : 1;

    localparam logic [DW-1:0]    LO_V      = DW'(LO);
    localparam logic [DW-1:0]    HI_V      = DW'(HI);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_LEN - 1);
    localparam logic [LAP_W-1:0] LAP_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic [DW-1:0]     prev_q,       prev_d;
    logic              have_prev_q,  have_prev_d;
    logic [RUN_W-1:0]  match_run_q,  match_run_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              err_q,        err_d;
    logic              err_sticky_q, err_sticky_d;
    logic [LAP_W-1:0]  lap_count_q,  lap_count_d;
    logic [ERR_W-1:0]  err_count_q,  err_count_d;

    logic [DW-1:0]     exp_cnt;
    logic              in_range;
    logic              step_ok;
    logic              lap_step;

    // Expected next value of the ramp and whether the current sample continues it.
    always_comb begin
        exp_cnt  = (prev_q >= HI_V) ? LO_V : (prev_q + DW'(1));
        in_range = (count >= LO_V) && (count <= HI_V);
        step_ok  = have_prev_q && (count == exp_cnt) && in_range;
        lap_step = (prev_q == HI_V) && (count == LO_V);
    end

    // Lock FSM, lap/error bookkeeping and the clear path; clr wins over any increment.
    always_comb begin
        state_d      = state_q;
        prev_d       = count;
        have_prev_d  = 1'b1;
        match_run_d  = match_run_q;
        wrap_pulse_d = 1'b0;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        lap_count_d  = lap_count_q;
        err_count_d  = err_count_q;

        unique case (state_q)
            ST_UNLOCKED: begin
                if (step_ok) begin
                    if (match_run_q == RUN_LAST) begin
                        state_d     = ST_LOCKED;
                        match_run_d = '0;
                    end else begin
                        match_run_d = match_run_q + RUN_W'(1);
                    end
                end else begin
                    match_run_d = '0;
                end
            end
            ST_LOCKED: begin
                if (step_ok) begin
                    // Only a HI->LO step closes a lap, so a lap in progress at lock time
                    // is counted once it reaches its own wrap.
                    if (lap_step) begin
                        wrap_pulse_d = 1'b1;
                        if (lap_count_q != LAP_MAX) begin
                            lap_count_d = lap_count_q + LAP_W'(1);
                        end
                    end
                end else begin
                    err_d        = 1'b1;
                    err_sticky_d = 1'b1;
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                // One dead cycle: the sample here only seeds prev_q for the relock attempt.
                state_d     = ST_UNLOCKED;
                match_run_d = '0;
            end
            default: begin
                state_d     = ST_UNLOCKED;
                match_run_d = '0;
            end
        endcase

        if (clr) begin
            lap_count_d  = '0;
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end
    end

    // State and output registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNLOCKED;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            match_run_q  <= '0;
            wrap_pulse_q <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            lap_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            match_run_q  <= match_run_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            lap_count_q  <= lap_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign wrap_pulse = wrap_pulse_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign lap_count  = lap_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_range_count_monitor.sv
// Bench for range_count_monitor: vector tables with a scoreboard, plus hand-written corner sequences.
// Latency: outputs are compared one cycle after each count sample.
// Backpressure: none; the bench drives one count per cycle.
module tb_range_count_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  count = 8'd3;
    logic        clr = 1'b0;
    logic        locked, wrap_pulse, err, err_sticky;
    logic [15:0] lap_count;
    logic [7:0]  err_count;

    logic [7:0]  count2 = 8'd3;
    logic        clr2 = 1'b0;
    logic        locked2, wrap2, err2, sticky2;
    logic [15:0] lap2;
    logic [1:0]  errc2;

    always #5 clk = ~clk;

    range_count_monitor dut (
        .clk(clk), .rst(rst), .count(count), .clr(clr),
        .locked(locked), .wrap_pulse(wrap_pulse), .lap_count(lap_count),
        .err(err), .err_sticky(err_sticky), .err_count(err_count)
    );

    range_count_monitor #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .count(count2), .clr(clr2),
        .locked(locked2), .wrap_pulse(wrap2), .lap_count(lap2),
        .err(err2), .err_sticky(sticky2), .err_count(errc2)
    );

    typedef struct {
        logic [7:0]  cnt;
        logic        clr;
        logic        locked;
        logic        wrap;
        logic        err;
        logic        sticky;
        logic [15:0] lap;
        logic [7:0]  errc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int n_vec = 0;
    int n_bad = 0;

    // Observations gathered while a table is applied.
    int obs_wraps, obs_hi, cur_low, max_low;

    // Reference model of the monitor (LO=3, HI=45, LOCK_LEN=4).
    logic [7:0]  m_prev;
    logic        m_have;
    int          m_run;
    int          m_st;      // 0 unlocked, 1 locked, 2 error
    logic        m_wrap, m_err, m_sticky;
    logic [15:0] m_lap;
    logic [7:0]  m_errc;

    task automatic model_reset();
        m_prev = 8'd0; m_have = 1'b0; m_run = 0; m_st = 0;
        m_wrap = 1'b0; m_err = 1'b0; m_sticky = 1'b0; m_lap = 16'd0; m_errc = 8'd0;
    endtask

    task automatic model_step(input logic [7:0] c, input logic cl);
        logic [7:0] e;
        logic       good;
        e    = (m_prev >= 8'd45) ? 8'd3 : m_prev + 8'd1;
        good = m_have && (c == e) && (c >= 8'd3) && (c <= 8'd45);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        case (m_st)
            0: begin
                if (good) begin
                    m_run++;
                    if (m_run == 4) begin m_st = 1; m_run = 0; end
                end else m_run = 0;
            end
            1: begin
                if (good) begin
                    if (m_prev == 8'd45 && c == 8'd3) begin
                        m_wrap = 1'b1;
                        if (m_lap != 16'hffff) m_lap++;
                    end
                end else begin
                    m_err = 1'b1; m_sticky = 1'b1;
                    if (m_errc != 8'hff) m_errc++;
                    m_st = 2;
                end
            end
            default: begin m_st = 0; m_run = 0; end
        endcase
        if (cl) begin m_lap = 16'd0; m_errc = 8'd0; m_sticky = 1'b0; end
        m_prev = c;
        m_have = 1'b1;
    endtask

    task automatic add(input logic [7:0] c, input logic cl);
        vec_t v;
        model_step(c, cl);
        v.cnt = c; v.clr = cl;
        v.locked = (m_st == 1); v.wrap = m_wrap; v.err = m_err; v.sticky = m_sticky;
        v.lap = m_lap; v.errc = m_errc;
        vecs.push_back(v);
    endtask

    task automatic add_ramp(input int from, input int to);
        for (int k = from; k <= to; k++) add(8'(k), 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Call at a negedge; drives each vector, compares after the next posedge, returns at a negedge.
    task automatic apply(input string tag);
        vec_t e;
        obs_wraps = 0; obs_hi = 0; cur_low = 0; max_low = 0;
        while (vecs.size() > 0) begin
            e = vecs.pop_front();
            count = e.cnt;
            clr   = e.clr;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_vec++;
            if ({locked, wrap_pulse, err, err_sticky, lap_count, err_count} !==
                {e.locked, e.wrap, e.err, e.sticky, e.lap, e.errc}) begin
                n_bad++;
                $display("FAIL %s cnt=%0d clr=%b: got lk=%b wr=%b er=%b st=%b lap=%0d ec=%0d expected lk=%b wr=%b er=%b st=%b lap=%0d ec=%0d",
                         tag, e.cnt, e.clr, locked, wrap_pulse, err, err_sticky, lap_count, err_count,
                         e.locked, e.wrap, e.err, e.sticky, e.lap, e.errc);
            end
            if (wrap_pulse) obs_wraps++;
            if (locked || wrap_pulse || err) obs_hi++;
            if (!locked) begin
                cur_low++;
                if (cur_low > max_low) max_low = cur_low;
            end else cur_low = 0;
            @(negedge clk);
        end
        clr = 1'b0;
    endtask

    task automatic drive2(input logic [7:0] c, input logic cl);
        count2 = c;
        clr2   = cl;
        @(posedge clk);
        #1;
        @(negedge clk);
        clr2 = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({locked, wrap_pulse, err, err_sticky, lap_count, err_count}), 0);
        rst = 1'b0;
        model_reset();

        // Free-running ramp: three full laps then the start of the fourth.
        for (int l = 0; l < 3; l++) add_ramp(3, 45);
        add(8'd3, 1'b0);
        apply("ramp");
        chk("ramp_lap_count", int'(lap_count), 3);
        chk("ramp_sticky", int'(err_sticky), 0);
        chk("ramp_wraps", obs_wraps, 3);

        // Counter reset mid-lap at 20, then relock and run on.
        add_ramp(4, 20);
        add_ramp(3, 30);
        apply("midlap");
        chk("midlap_err_count", int'(err_count), 1);
        chk("midlap_unlocked_len", int'(max_low >= 5), 1);
        chk("midlap_no_wrap", obs_wraps, 0);

        // Out-of-range value while locked.
        add_ramp(31, 32);
        add(8'd50, 1'b0);
        apply("oor");
        chk("oor_err", int'(err), 1);
        chk("oor_sticky", int'(err_sticky), 1);

        // Relock, then clear while locked.
        add_ramp(3, 8);
        add(8'd9, 1'b1);
        apply("clr");
        chk("clr_locked", int'(locked), 1);
        chk("clr_lap", int'(lap_count), 0);
        chk("clr_err_count", int'(err_count), 0);
        chk("clr_sticky", int'(err_sticky), 0);

        // Counter held at LO after reset must never lock.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) add(8'd3, 1'b0);
        apply("hold_lo");
        chk("hold_lo_quiet", obs_hi, 0);

        // Lock, then reset asynchronously in the middle of the low clock phase.
        add_ramp(4, 10);
        apply("prereset");
        chk("prereset_locked", int'(locked), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({locked, wrap_pulse, err, err_sticky, lap_count, err_count}), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Saturation of a 2-bit error counter, then clear racing an error.
        for (int b = 0; b < 5; b++) begin
            for (int k = 3; k <= 7; k++) drive2(8'(k), 1'b0);
            chk("sat_locked_before_err", int'(locked2), 1);
            drive2(8'd50, 1'b0);
        end
        chk("sat_err_count", int'(errc2), 3);
        chk("sat_sticky", int'(sticky2), 1);
        for (int k = 3; k <= 7; k++) drive2(8'(k), 1'b0);
        drive2(8'd50, 1'b1);
        chk("clr_vs_err_pulse", int'(err2), 1);
        chk("clr_vs_err_count", int'(errc2), 0);
        chk("clr_vs_err_sticky", int'(sticky2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
